// File: rtl/i2c_bus_arbiter.sv
// i2c_bus_arbiter: grants the shared open-drain I2C pads to one of two masters per
// transaction, gated on bus-free time, with a hold watchdog, 9-clock recovery and STOP.
module i2c_bus_arbiter #(
   parameter int unsigned BUS_FREE_CYCLES = 134,
   parameter int unsigned TIMEOUT_CYCLES  = 2800000,
   parameter int unsigned HALF_PERIOD     = 140
) (
   input  logic clk,
   input  logic rst,
   input  logic req0,
   input  logic req1,
   output logic gnt0,
   output logic gnt1,
   input  logic m0_scl_t,
   input  logic m0_sda_t,
   input  logic m1_scl_t,
   input  logic m1_sda_t,
   input  logic scl_i,
   input  logic sda_i,
   output logic scl_t,
   output logic sda_t,
   output logic bus_free,
   output logic timeout
);

   // state        | meaning
   // ST_IDLE      | pads released, waiting for bus_free and an eligible request
   // ST_GRANT0    | master 0 owns the pads
   // ST_GRANT1    | master 1 owns the pads
   // ST_REC_LOW   | recovery clock, SCL low phase
   // ST_REC_HIGH  | recovery clock, SCL high phase (counts only while SCL reads high)
   // ST_STOP_LOW  | STOP setup: SCL low, SDA low
   // ST_STOP_HIGH | STOP: SCL released, SDA low until SCL has been high long enough

   localparam int FREE_W = $clog2(BUS_FREE_CYCLES + 1);
   localparam int HOLD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int HALF_W = $clog2(HALF_PERIOD + 1);

   localparam logic [FREE_W-1:0] FREE_MAX   = FREE_W'(BUS_FREE_CYCLES);
   localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(TIMEOUT_CYCLES - 1);
   localparam logic [HALF_W-1:0] HALF_LOAD  = HALF_W'(HALF_PERIOD - 1);
   localparam logic [3:0]        LAST_PULSE = 4'd8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_GRANT0,
      ST_GRANT1,
      ST_REC_LOW,
      ST_REC_HIGH,
      ST_STOP_LOW,
      ST_STOP_HIGH
   } state_t;

   state_t            state_q, state_d;
   logic              scl_s1, scl_s2, sda_s1, sda_s2;
   logic [FREE_W-1:0] free_cnt;
   logic [HOLD_W-1:0] hold_cnt, hold_d;
   logic [HALF_W-1:0] half_cnt, half_d;
   logic [3:0]        pulse_cnt, pulse_d;
   logic              last_gnt, last_d;
   logic              block0, block1, block0_d, block1_d;
   logic              gnt0_d, gnt1_d, scl_d, sda_d, timeout_d;
   logic              elig0, elig1;

   always_ff @(posedge clk) begin
      if (rst) begin
         scl_s1 <= 1'b0;
         scl_s2 <= 1'b0;
         sda_s1 <= 1'b0;
         sda_s2 <= 1'b0;
      end else begin
         scl_s1 <= scl_i;
         scl_s2 <= scl_s1;
         sda_s1 <= sda_i;
         sda_s2 <= sda_s1;
      end
   end

   // Held at zero outside IDLE so that every new owner waits a full bus-free window,
   // even if the previous owner left both lines high.
   always_ff @(posedge clk) begin
      if (rst) begin
         free_cnt <= '0;
      end else if (state_q != ST_IDLE || !scl_s2 || !sda_s2) begin
         free_cnt <= '0;
      end else if (free_cnt != FREE_MAX) begin
         free_cnt <= free_cnt + 1'b1;
      end
   end

   assign bus_free = (free_cnt == FREE_MAX);
   assign elig0    = req0 & ~block0;
   assign elig1    = req1 & ~block1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         gnt0      <= 1'b0;
         gnt1      <= 1'b0;
         scl_t     <= 1'b1;
         sda_t     <= 1'b1;
         timeout   <= 1'b0;
         hold_cnt  <= '0;
         half_cnt  <= '0;
         pulse_cnt <= '0;
         last_gnt  <= 1'b1;
         block0    <= 1'b0;
         block1    <= 1'b0;
      end else begin
         state_q   <= state_d;
         gnt0      <= gnt0_d;
         gnt1      <= gnt1_d;
         scl_t     <= scl_d;
         sda_t     <= sda_d;
         timeout   <= timeout_d;
         hold_cnt  <= hold_d;
         half_cnt  <= half_d;
         pulse_cnt <= pulse_d;
         last_gnt  <= last_d;
         block0    <= block0_d;
         block1    <= block1_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      gnt0_d    = 1'b0;
      gnt1_d    = 1'b0;
      scl_d     = 1'b1;
      sda_d     = 1'b1;
      timeout_d = 1'b0;
      hold_d    = hold_cnt;
      half_d    = half_cnt;
      pulse_d   = pulse_cnt;
      last_d    = last_gnt;
      block0_d  = block0 & req0;
      block1_d  = block1 & req1;

      unique case (state_q)
         ST_IDLE: begin
            if (bus_free && (elig0 || elig1)) begin
               hold_d = '0;
               // last_gnt == 1 means master 1 went last, so master 0 wins a tie
               if (elig0 && (!elig1 || last_gnt)) begin
                  state_d = ST_GRANT0;
                  gnt0_d  = 1'b1;
                  scl_d   = m0_scl_t;
                  sda_d   = m0_sda_t;
                  last_d  = 1'b0;
               end else begin
                  state_d = ST_GRANT1;
                  gnt1_d  = 1'b1;
                  scl_d   = m1_scl_t;
                  sda_d   = m1_sda_t;
                  last_d  = 1'b1;
               end
            end
         end

         ST_GRANT0: begin
            if (!req0) begin
               state_d = ST_IDLE;
            end else if (hold_cnt == HOLD_LAST) begin
               state_d   = ST_REC_LOW;
               timeout_d = 1'b1;
               block0_d  = 1'b1;
               scl_d     = 1'b0;
               half_d    = HALF_LOAD;
               pulse_d   = '0;
            end else begin
               gnt0_d = 1'b1;
               scl_d  = m0_scl_t;
               sda_d  = m0_sda_t;
               hold_d = hold_cnt + 1'b1;
            end
         end

         ST_GRANT1: begin
            if (!req1) begin
               state_d = ST_IDLE;
            end else if (hold_cnt == HOLD_LAST) begin
               state_d   = ST_REC_LOW;
               timeout_d = 1'b1;
               block1_d  = 1'b1;
               scl_d     = 1'b0;
               half_d    = HALF_LOAD;
               pulse_d   = '0;
            end else begin
               gnt1_d = 1'b1;
               scl_d  = m1_scl_t;
               sda_d  = m1_sda_t;
               hold_d = hold_cnt + 1'b1;
            end
         end

         ST_REC_LOW: begin
            scl_d = 1'b0;
            if (half_cnt == '0) begin
               state_d = ST_REC_HIGH;
               scl_d   = 1'b1;
               half_d  = HALF_LOAD;
            end else begin
               half_d = half_cnt - 1'b1;
            end
         end

         // The high phase is timed from when the synchronized SCL reads high, so a
         // stretching slave (and the synchronizer delay) lengthen it.
         ST_REC_HIGH: begin
            if (scl_s2) begin
               if (half_cnt == '0) begin
                  scl_d  = 1'b0;
                  half_d = HALF_LOAD;
                  if (pulse_cnt == LAST_PULSE) begin
                     state_d = ST_STOP_LOW;
                     sda_d   = 1'b0;
                  end else begin
                     state_d = ST_REC_LOW;
                     pulse_d = pulse_cnt + 1'b1;
                  end
               end else begin
                  half_d = half_cnt - 1'b1;
               end
            end
         end

         ST_STOP_LOW: begin
            scl_d = 1'b0;
            sda_d = 1'b0;
            if (half_cnt == '0) begin
               state_d = ST_STOP_HIGH;
               scl_d   = 1'b1;
               half_d  = HALF_LOAD;
            end else begin
               half_d = half_cnt - 1'b1;
            end
         end

         ST_STOP_HIGH: begin
            sda_d = 1'b0;
            if (scl_s2) begin
               if (half_cnt == '0) begin
                  state_d = ST_IDLE;
                  sda_d   = 1'b1;
               end else begin
                  half_d = half_cnt - 1'b1;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed bench for i2c_bus_arbiter: grant timing, round robin, release, watchdog
// recovery with clock stretching, STOP, blocking and mid-grant reset.
module tb_i2c_bus_arbiter;

   localparam int S_SCL  = 0;
   localparam int S_SDA  = 1;
   localparam int S_GNT0 = 2;
   localparam int S_GNT1 = 3;

   logic clk, rst, req0, req1;
   logic gnt0, gnt1, m0_scl_t, m0_sda_t, m1_scl_t, m1_sda_t;
   logic scl_i, sda_i, scl_t, sda_t, bus_free, timeout;
   logic stretch, sda_pull, both_seen;
   int   total, bad, tmo_seen, cyc, len;

   i2c_bus_arbiter #(
      .BUS_FREE_CYCLES(134),
      .TIMEOUT_CYCLES (1000),
      .HALF_PERIOD    (4)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .req0    (req0),
      .req1    (req1),
      .gnt0    (gnt0),
      .gnt1    (gnt1),
      .m0_scl_t(m0_scl_t),
      .m0_sda_t(m0_sda_t),
      .m1_scl_t(m1_scl_t),
      .m1_sda_t(m1_sda_t),
      .scl_i   (scl_i),
      .sda_i   (sda_i),
      .scl_t   (scl_t),
      .sda_t   (sda_t),
      .bus_free(bus_free),
      .timeout (timeout)
   );

   // open-drain wire: the pad drive plus an optional slave holding the line low
   assign scl_i = scl_t & ~stretch;
   assign sda_i = sda_t & ~sda_pull;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (gnt0 === 1'b1 && gnt1 === 1'b1) both_seen = 1'b1;
      if (timeout === 1'b1) tmo_seen++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic sig(input int sel);
      case (sel)
         S_SCL:   return scl_t;
         S_SDA:   return sda_t;
         S_GNT0:  return gnt0;
         default: return gnt1;
      endcase
   endfunction

   task automatic wait_grant(input int bound, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(gnt0 === 1'b1 || gnt1 === 1'b1) && n < bound);
   endtask

   task automatic run_len(input int sel, input logic val, input int bound, output int n);
      n = 0;
      while (sig(sel) === val && n < bound) begin
         n++;
         @(negedge clk);
      end
   endtask

   initial begin
      total = 0; bad = 0; tmo_seen = 0; both_seen = 1'b0;
      rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
      m0_scl_t = 1'b1; m0_sda_t = 1'b1; m1_scl_t = 1'b1; m1_sda_t = 1'b1;
      stretch = 1'b0; sda_pull = 1'b0;
      repeat (3) @(negedge clk);
      check("rst gnt0", gnt0, 1'b0);
      check("rst gnt1", gnt1, 1'b0);
      check("rst scl_t", scl_t, 1'b1);
      check("rst sda_t", sda_t, 1'b1);
      check("rst timeout", timeout, 1'b0);
      check("rst bus_free", bus_free, 1'b0);

      // bus_free after 2 sync + 134 free cycles, grant one cycle later
      rst = 1'b0; req1 = 1'b1;
      repeat (135) @(negedge clk);
      check("bus_free at 135", bus_free, 1'b0);
      @(negedge clk);
      check("bus_free at 136", bus_free, 1'b1);
      check("gnt1 at 136", gnt1, 1'b0);
      @(negedge clk);
      check("gnt1 at 137", gnt1, 1'b1);
      check("gnt0 at 137", gnt0, 1'b0);

      m1_scl_t = 1'b0;
      #1 check("scl latency", scl_t, 1'b1);
      @(negedge clk);
      check("scl follows m1", scl_t, 1'b0);
      m1_sda_t = 1'b0;
      @(negedge clk);
      check("sda follows m1", sda_t, 1'b0);
      m1_scl_t = 1'b1; m1_sda_t = 1'b1; m0_scl_t = 1'b0; m0_sda_t = 1'b0;
      repeat (2) @(negedge clk);
      check("m0 scl ignored", scl_t, 1'b1);
      check("m0 sda ignored", sda_t, 1'b1);

      // reset mid-grant with the owner pulling SCL low
      m0_scl_t = 1'b1; m0_sda_t = 1'b1; m1_scl_t = 1'b0;
      @(negedge clk);
      check("scl low pre-rst", scl_t, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      check("midrst gnt1", gnt1, 1'b0);
      check("midrst scl_t", scl_t, 1'b1);
      check("midrst sda_t", sda_t, 1'b1);
      check("midrst timeout", timeout, 1'b0);
      @(negedge clk);
      rst = 1'b0; req0 = 1'b1; m1_scl_t = 1'b1;
      wait_grant(300, cyc);
      check("tie grant cycle", cyc, 137);
      check("tie gnt0", gnt0, 1'b1);
      check("tie gnt1", gnt1, 1'b0);

      // release master 0: master 1 follows after a fresh bus-free window
      req0 = 1'b0;
      @(negedge clk);
      check("rel gnt0", gnt0, 1'b0);
      check("rel gnt1", gnt1, 1'b0);
      check("rel scl_t", scl_t, 1'b1);
      wait_grant(300, cyc);
      check("handover cycle", cyc, 135);
      check("handover gnt1", gnt1, 1'b1);

      // master 0 holds too long: watchdog, recovery, STOP
      req1 = 1'b0; req0 = 1'b1;
      @(negedge clk);
      check("rel1 gnt1", gnt1, 1'b0);
      wait_grant(300, cyc);
      check("grant0 cycle", cyc, 135);
      run_len(S_GNT0, 1'b1, 2000, len);
      check("hold length", len, 1000);
      check("timeout pulse", timeout, 1'b1);
      check("tmo gnt0", gnt0, 1'b0);
      run_len(S_SCL, 1'b0, 100, len);
      check("rec low 0", len, 4);
      check("timeout one cycle", timeout, 1'b0);
      for (int p = 0; p < 9; p++) begin
         if (p > 0) begin
            run_len(S_SCL, 1'b0, 100, len);
            check("rec low", len, 4);
         end
         check("rec sda released", sda_t, 1'b1);
         if (p == 3) begin
            stretch = 1'b1;
            repeat (20) @(negedge clk);
            check("stretched scl", scl_t, 1'b1);
            stretch = 1'b0;
            run_len(S_SCL, 1'b1, 100, len);
            check("stretch tail", len, 6);
         end else begin
            // HALF_PERIOD plus 2 cycles of synchronizer latency before counting
            run_len(S_SCL, 1'b1, 100, len);
            check("rec high", len, 6);
         end
      end
      check("stop sda low", sda_t, 1'b0);
      run_len(S_SCL, 1'b0, 100, len);
      check("stop scl low", len, 4);
      check("stop scl high", scl_t, 1'b1);
      run_len(S_SDA, 1'b0, 100, len);
      check("stop sda hold", len, 6);
      check("stop sda release", sda_t, 1'b1);
      check("stop gnt0", gnt0, 1'b0);

      // still blocked while req0 stays high
      wait_grant(300, cyc);
      check("blocked no grant", cyc, 300);
      check("blocked bus_free", bus_free, 1'b1);
      req0 = 1'b0;
      @(negedge clk);
      req0 = 1'b1;
      wait_grant(300, cyc);
      check("unblock cycle", cyc, 1);
      check("unblock gnt0", gnt0, 1'b1);

      // release on the watchdog cycle wins: no timeout, no block
      repeat (999) @(negedge clk);
      check("hold 1000 gnt0", gnt0, 1'b1);
      req0 = 1'b0;
      @(negedge clk);
      check("race gnt0", gnt0, 1'b0);
      check("race timeout", timeout, 1'b0);
      req0 = 1'b1;
      wait_grant(300, cyc);
      check("race regrant cycle", cyc, 135);
      check("race regrant gnt0", gnt0, 1'b1);
      req0 = 1'b0;
      @(negedge clk);

      // a one-cycle SDA low restarts the bus-free window
      repeat (140) @(negedge clk);
      check("idle bus_free", bus_free, 1'b1);
      sda_pull = 1'b1;
      @(negedge clk);
      sda_pull = 1'b0;
      repeat (2) @(negedge clk);
      check("glitch clears", bus_free, 1'b0);
      repeat (133) @(negedge clk);
      check("refree at 133", bus_free, 1'b0);
      @(negedge clk);
      check("refree at 134", bus_free, 1'b1);

      check("never both granted", both_seen, 1'b0);
      check("timeout count", tmo_seen, 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/i2c_bus_arbiter.md
Name: i2c_bus_arbiter

Overview:
Shares the single open-drain I2C bus (io_scl/io_sda) between two masters: master 0, the Minimig core I2C controller, and master 1, the ADV7511/MAX9850 configuration sender. It grants exclusive ownership per transaction, waits for bus-free time between owners, and forces released lines for the non-owner. A stuck owner is revoked by a watchdog, which is followed by a 9-clock bus recovery and a STOP. Sits in the board top between both masters' SCL/SDA tristate controls and the pad logic.

Parameters:
BUS_FREE_CYCLES, 134, cycles with SCL and SDA both high before a grant is allowed (4.7 us at 28 MHz).
TIMEOUT_CYCLES, 2800000, maximum cycles one grant may be held (100 ms at 28 MHz).
HALF_PERIOD, 140, half-period of recovery SCL in cycles (100 kHz at 28 MHz).

Ports:
clk  in  1  system clock (clk_28 domain)
rst  in  1  synchronous reset, active-high
req0  in  1  master 0 bus request, level; hold high for the whole transaction
req1  in  1  master 1 bus request
gnt0  out  1  master 0 owns bus
gnt1  out  1  master 1 owns bus
m0_scl_t  in  1  master 0 SCL tristate (0 = drive low)
m0_sda_t  in  1  master 0 SDA tristate
m1_scl_t  in  1  master 1 SCL tristate
m1_sda_t  in  1  master 1 SDA tristate
scl_i  in  1  bus SCL sense, asynchronous
sda_i  in  1  bus SDA sense, asynchronous
scl_t  out  1  SCL pad tristate (0 = pull low)
sda_t  out  1  SDA pad tristate
bus_free  out  1  bus idle for BUS_FREE_CYCLES
timeout  out  1  one-cycle pulse on watchdog revoke

Behaviour:
- Reset values: gnt0=gnt1=0, scl_t=sda_t=1, timeout=0, bus_free=0. State is IDLE. The last-granted register is set to 1, so master 0 wins the first tie. All counters are 0 and both block flags are clear.
- scl_i and sda_i pass through a 2-flop synchronizer; internal logic uses only the synchronized values.
- Free counter: increments while both synchronized lines are high and saturates at BUS_FREE_CYCLES. It clears on any low. bus_free = (count == BUS_FREE_CYCLES).
- IDLE: when bus_free is high and an eligible request is present (reqN=1 and blockN=0), go to GRANTN.
  - gntN is registered high on the next edge.
  - If both are eligible, grant the master that was not last granted (round-robin). Update the last-granted register.
- GRANTN:
  - scl_t/sda_t are registered from mN_scl_t/mN_sda_t, giving one cycle of latency.
  - The non-owner's tristate inputs are ignored.
  - A hold counter clears on grant and increments each cycle.
- Release: when reqN=0 in GRANTN, on the next edge gntN=0, scl_t=sda_t=1, and the state returns to IDLE. A new grant then needs bus_free again.
- Watchdog: if the hold counter reaches TIMEOUT_CYCLES-1 while reqN is still 1:
  - gntN=0 and timeout=1 for one cycle.
  - blockN is set; it clears only when reqN is seen low.
  - The state goes to RECOVER.
  - If reqN drops on the same cycle, the release wins: no timeout and no block.
- RECOVER: sda_t=1; emit 9 SCL pulses, each low for HALF_PERIOD and high for HALF_PERIOD.
  - The high-phase count starts only once the synchronized SCL reads high (clock stretching honoured).
- STOP sequence:
  - P1: SCL low, SDA low for HALF_PERIOD.
  - P2: SCL released, SDA low for HALF_PERIOD after SCL is seen high.
  - Then SDA is released and the state returns to IDLE.
- Requests arriving during RECOVER/STOP are held off until IDLE and bus_free.
- Never more than one of gnt0/gnt1 is high. scl_t/sda_t equal 1 whenever no grant is active and the state is not RECOVER/STOP.
- A rst assertion mid-grant or mid-recovery returns everything to reset values on the next edge.

Test Plan:
- Lines high 200 cycles, req1=1 -> bus_free high at cycle 136 (2 synchronizer cycles + 134); gnt1 high the cycle after; scl_t follows m1_scl_t one cycle late.
- req0 and req1 rise together after reset -> gnt0 first. Drop req0 with req1 still high -> gnt1 follows after 134 free cycles; gnt0 and gnt1 never both high.
- During gnt1, toggle m0_scl_t/m0_sda_t low -> scl_t/sda_t unaffected.
- Hold req0 with TIMEOUT_CYCLES=1000, HALF_PERIOD=4 -> timeout pulse at hold cycle 1000; then 9 SCL pulses of 4 low/4 high, then STOP; gnt0 stays 0 until req0 goes low and then high again.
- In RECOVER, hold scl_i low 20 cycles during a high phase -> the high phase extends by 20 cycles; pulse count is still 9.
- Assert rst mid-grant -> next edge gnt=0, scl_t=sda_t=1, timeout=0; the first grant after reset is again round-robin with master 0 preferred.
